// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute,
// memory and writeback control for a 6-bit PC, 16-bit ISA.
module instr_sequencer #(
  parameter logic [5:0] PC_RESET = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] instr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        alu_bool,
  output logic [15:0] ir,
  output logic [5:0]  pc,
  output logic        exec_en,
  output logic        wb_en,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_BAD       = 3'd7
  } state_t;

  state_t      st_q, st_d;
  logic [5:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  logic [1:0]  ityp;
  logic [4:0]  opc;
  logic [5:0]  target;
  logic [5:0]  pc_inc;
  logic        is_load, is_store, is_jump;
  logic        is_branch, is_wb;

  assign ityp   = ir_q[15:14];
  assign opc    = ir_q[13:9];
  assign target = ir_q[8:3];
  assign pc_inc = pc_q + 6'd1;

  assign is_load   = (ityp == 2'b01) && (opc == 5'b01111);
  assign is_store  = (ityp == 2'b01) && (opc == 5'b10001);
  assign is_jump   = (ityp == 2'b10) && (opc == 5'b10010);
  assign is_branch = (ityp == 2'b10) && (opc == 5'b10011);
  // ALU register ops plus the immediate forms that write a result
  assign is_wb = (ityp == 2'b00)
              || ((ityp == 2'b01)
                  && ((opc[4:2] == 3'b000 && opc[0])
                   || (opc[4:1] == 4'b0011)
                   || (opc == 5'b10000)));

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= S_IDLE;
      pc_q <= PC_RESET;
      ir_q <= 16'h0000;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    exec_en  = 1'b0;
    wb_en    = 1'b0;
    halted   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) st_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d = instr_in;
          st_d = S_DECODE;
        end
      end
      S_DECODE: begin
        st_d = (ityp == 2'b11) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        exec_en = 1'b1;
        st_d    = S_FETCH;
        unique case (1'b1)
          is_load, is_store: st_d = S_MEM;
          is_jump:           pc_d = target;
          is_branch:         pc_d = alu_bool ? target : pc_inc;
          is_wb:             st_d = S_WRITEBACK;
          default:           pc_d = pc_inc;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_d = pc_inc;
            st_d = S_FETCH;
          end else begin
            st_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        wb_en = 1'b1;
        pc_d  = pc_inc;
        st_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = st_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table of instructions run through
// a scoreboard, plus halt and reset-in-MEM sequences.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        imem_req, imem_ack;
  logic [5:0]  imem_addr;
  logic [15:0] instr_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        alu_bool;
  logic [15:0] ir;
  logic [5:0]  pc;
  logic        exec_en, wb_en, halted;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr_in(instr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .alu_bool(alu_bool),
    .ir(ir), .pc(pc), .exec_en(exec_en),
    .wb_en(wb_en), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        alu;
    int          dwait;
    int          cyc;
    int          wbn;
    int          exn;
    int          memn;
    logic        we;
    logic [5:0]  pc;
    logic [2:0]  st;
    logic [31:0] seq;
  } vec_t;

  vec_t tbl[13];
  vec_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_instr(input logic [15:0] instr,
                           input logic alu,
                           input int dwait,
                           output int cyc, output int wbn,
                           output int exn, output int memn,
                           output logic we,
                           output logic [31:0] seq);
    cyc = 0; wbn = 0; exn = 0; memn = 0;
    we = 1'b0; seq = '0;
    instr_in = instr;
    imem_ack = 1'b1;
    alu_bool = ~alu;
    step();
    cyc = 1;
    seq = {seq[28:0], state};
    imem_ack = 1'b0;
    instr_in = 16'hFFFF;
    while (state != 3'd1 && state != 3'd6 && cyc < 40) begin
      if (wb_en) wbn++;
      if (exec_en) exn++;
      alu_bool = (state == 3'd3) ? alu : ~alu;
      if (state == 3'd4) begin
        memn++;
        we |= dmem_we;
        dmem_ack = (memn > dwait);
      end else begin
        dmem_ack = 1'b0;
      end
      step();
      cyc++;
      seq = {seq[28:0], state};
    end
    dmem_ack = 1'b0;
    alu_bool = 1'b0;
  endtask

  initial begin
    int cyc, wbn, exn, memn;
    logic we;
    logic [31:0] seq;
    logic [5:0] exp_addr;
    vec_t e;

    //       instr     alu  dw cyc wb ex mem we  pc    st    seq
    tbl[0]  = '{16'h0000, 1'b0, 0, 4, 1, 1, 0, 1'b0, 6'd1,  3'd1, 32'o2351};
    tbl[1]  = '{16'h5E45, 1'b0, 3, 8, 1, 1, 4, 1'b0, 6'd2,  3'd1, 32'o23444451};
    tbl[2]  = '{16'h6205, 1'b0, 0, 4, 0, 1, 1, 1'b1, 6'd3,  3'd1, 32'o2341};
    tbl[3]  = '{16'hA628, 1'b1, 0, 3, 0, 1, 0, 1'b0, 6'd5,  3'd1, 32'o231};
    tbl[4]  = '{16'hA628, 1'b0, 0, 3, 0, 1, 0, 1'b0, 6'd6,  3'd1, 32'o231};
    tbl[5]  = '{16'h4600, 1'b0, 0, 4, 1, 1, 0, 1'b0, 6'd7,  3'd1, 32'o2351};
    tbl[6]  = '{16'h4800, 1'b0, 0, 3, 0, 1, 0, 1'b0, 6'd8,  3'd1, 32'o231};
    tbl[7]  = '{16'hA5F8, 1'b0, 0, 3, 0, 1, 0, 1'b0, 6'd63, 3'd1, 32'o231};
    tbl[8]  = '{16'h4800, 1'b0, 0, 3, 0, 1, 0, 1'b0, 6'd0,  3'd1, 32'o231};
    tbl[9]  = '{16'h4000, 1'b0, 0, 3, 0, 1, 0, 1'b0, 6'd1,  3'd1, 32'o231};
    tbl[10] = '{16'h8000, 1'b1, 0, 3, 0, 1, 0, 1'b0, 6'd2,  3'd1, 32'o231};
    tbl[11] = '{16'h2000, 1'b0, 0, 4, 1, 1, 0, 1'b0, 6'd3,  3'd1, 32'o2351};
    tbl[12] = '{16'hC000, 1'b0, 0, 2, 0, 0, 0, 1'b0, 6'd3,  3'd6, 32'o26};

    reset = 1'b1; start = 1'b0;
    imem_ack = 1'b0; instr_in = 16'h0;
    dmem_ack = 1'b0; alu_bool = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 6'd0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_strobes",
        {imem_req, dmem_req, dmem_we, exec_en, wb_en, halted}, 6'd0);

    imem_ack = 1'b1; instr_in = 16'h1234;
    step(); step();
    imem_ack = 1'b0;
    chk("idle_hold", state, 3'd0);
    chk("idle_ir", ir, 16'h0);
    chk("idle_pc", pc, 6'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_fetch", state, 3'd1);

    exp_addr = 6'd0;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_imem_req", i), imem_req, 1'b1);
      chk($sformatf("v%0d_imem_addr", i), imem_addr, exp_addr);
      sb.push_back(tbl[i]);
      run_instr(tbl[i].instr, tbl[i].alu, tbl[i].dwait,
                cyc, wbn, exn, memn, we, seq);
      e = sb.pop_front();
      chk($sformatf("v%0d_cycles", i), cyc, e.cyc);
      chk($sformatf("v%0d_wb", i), wbn, e.wbn);
      chk($sformatf("v%0d_exec", i), exn, e.exn);
      chk($sformatf("v%0d_mem", i), memn, e.memn);
      chk($sformatf("v%0d_we", i), we, e.we);
      chk($sformatf("v%0d_pc", i), pc, e.pc);
      chk($sformatf("v%0d_state", i), state, e.st);
      chk($sformatf("v%0d_seq", i), seq, e.seq);
      chk($sformatf("v%0d_ir", i), ir, e.instr);
      exp_addr = e.pc;
    end

    start = 1'b1; imem_ack = 1'b1; instr_in = 16'h0000;
    dmem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halt_hold", state, 3'd6);
      chk("halt_flag", halted, 1'b1);
    end
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("halt_ir", ir, 16'hC000);
    chk("halt_pc", pc, 6'd3);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_rst_state", state, 3'd0);
    chk("halt_rst_halted", halted, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    instr_in = 16'h5E45; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step(); step();
    chk("mem_reached", state, 3'd4);
    chk("mem_req", dmem_req, 1'b1);
    reset = 1'b1; dmem_ack = 1'b1;
    step();
    reset = 1'b0; dmem_ack = 1'b0;
    chk("memrst_state", state, 3'd0);
    chk("memrst_pc", pc, 6'd0);
    chk("memrst_dreq", dmem_req, 1'b0);
    chk("memrst_wb", wb_en, 1'b0);
    chk("memrst_ir", ir, 16'h0);
    step();
    chk("memrst_idle", state, 3'd0);
    chk("memrst_wb2", wb_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have the parameter PC_RESET, default 6'd0, which is the PC value loaded on reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: begins execution from IDLE.
REQ-005 The block SHALL have the ports imem_req (output, 1 bit), imem_addr (output, 6 bits), imem_ack (input, 1 bit) and instr_in (input, 16 bits): the instruction fetch handshake.
REQ-006 The block SHALL have the ports dmem_req (output, 1 bit), dmem_we (output, 1 bit) and dmem_ack (input, 1 bit): the data memory handshake.
REQ-007 The block SHALL have the port alu_bool, input, 1 bit: the branch condition from the ALU.
REQ-008 The block SHALL have the port ir, output, 16 bits: the latched instruction register.
REQ-009 The block SHALL have the port pc, output, 6 bits: the program counter.
REQ-010 The block SHALL have the ports exec_en, wb_en and halted, each an output of 1 bit: datapath strobes and the halt flag.
REQ-011 The block SHALL have the port state, output, 3 bits: the current FSM state, for debug.

Function
REQ-012 Instruction fields SHALL be decoded from ir as follows: type = ir[15:14] and opcode = ir[13:9]. Types: 00 = register, 01 = immediate/memory, 10 = control, 11 = halt.
REQ-013 The FSM SHALL have the states and encodings IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6; encoding 7 SHALL go to IDLE on the next edge.
REQ-014 In IDLE, start=1 SHALL move the FSM to FETCH; otherwise the FSM SHALL hold in IDLE, with pc unchanged.
REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; on imem_ack=1 the block SHALL set ir<=instr_in and move to DECODE; otherwise it SHALL wait indefinitely with no timeout.
REQ-016 DECODE SHALL last exactly 1 cycle: type 11 SHALL move to HALT, and all other types SHALL move to EXECUTE.
REQ-017 exec_en SHALL be 1 for exactly the one cycle spent in EXECUTE.
REQ-018 EXECUTE, type 01 with opcode 01111 (load) or 10001 (store) SHALL move to MEM.
REQ-019 EXECUTE, type 10 with opcode 10010 (jump) SHALL set pc<=ir[8:3] and move to FETCH.
REQ-020 EXECUTE, type 10 with opcode 10011 (branch) SHALL set pc<=ir[8:3] if alu_bool=1, else pc<=pc+1, and move to FETCH; alu_bool SHALL be sampled in the EXECUTE cycle only.
REQ-021 EXECUTE, type 00, or type 01 with opcode 000x1, 0011x or 10000, SHALL move to WRITEBACK.
REQ-022 EXECUTE with any other type 01 or type 10 opcode SHALL set pc<=pc+1 and move to FETCH, with no writeback (treated as a NOP).
REQ-023 In MEM, dmem_req SHALL be 1 and dmem_we SHALL be 1 for a store, 0 for a load.
REQ-024 In MEM, on dmem_ack=1 a load SHALL move to WRITEBACK; a store SHALL set pc<=pc+1 and move to FETCH.
REQ-025 wb_en SHALL be 1 for exactly the one cycle spent in WRITEBACK; WRITEBACK SHALL then set pc<=pc+1 and move to FETCH.
REQ-026 In HALT, halted SHALL be 1; the FSM SHALL hold until reset, and start SHALL be ignored.
REQ-027 PC arithmetic SHALL be 6-bit modulo: pc=63 incremented SHALL give 0.
REQ-028 imem_req, dmem_req, dmem_we, exec_en, wb_en and halted SHALL be pure decodes of the state register (Moore) and SHALL be 0 in all other states.
REQ-029 imem_ack outside FETCH, dmem_ack outside MEM, and start outside IDLE SHALL be ignored.
REQ-030 ir SHALL change only on an accepted fetch (imem_ack in FETCH).
REQ-031 Instruction latency SHALL be, counted from the FETCH cycle in which ack arrives, with 0-wait memories: 4 cycles for ALU operations, 3 for jump/branch, 5 for load, and 4 for store.

Reset
REQ-032 When reset=1 at a rising edge, the block SHALL set state=IDLE, pc=PC_RESET, ir=16'h0000, and all strobes and halted to 0, overriding every other input.
REQ-033 A reset asserted during FETCH or MEM SHALL drop imem_req or dmem_req in the cycle after the edge; any pending ack SHALL be discarded.
REQ-034 Reset SHALL be the only exit from HALT.

Verification
REQ-035 The bench SHALL apply reset, then start=1 with a 0-wait imem returning 16'h0000 (type 00) at address 0, and SHALL require the state sequence FETCH, DECODE, EXECUTE, WRITEBACK, FETCH, with wb_en pulsed once and pc=1.
REQ-036 The bench SHALL run a load 16'h5E45 (type 01, opcode 01111) with dmem_ack delayed 3 cycles, and SHALL require dmem_req=1 and dmem_we=0 for 4 cycles, then WRITEBACK, then pc+1.
REQ-037 The bench SHALL run a store 16'h6205 (opcode 10001) and SHALL require dmem_we=1, no wb_en, and pc+1 after the ack.
REQ-038 The bench SHALL run a branch 16'hA628 (opcode 10011, target 5) with alu_bool=1 and SHALL require pc=5; with alu_bool=0 it SHALL require pc=old+1.
REQ-039 The bench SHALL run a jump with pc=63 and a NOP at 63, and SHALL require the wrap to pc=0; a 16'hC000 instruction SHALL cause HALT with halted=1, and start=1 there SHALL be ignored.
REQ-040 The bench SHALL assert reset while in MEM with dmem_ack=1 on the same edge, and SHALL require state=IDLE, pc=0, dmem_req=0 on the next cycle, and no wb_en.
